// File: rtl/bbus_master.sv
// SNES B-bus initiator: runs one PA/PD read or write cycle per accepted command,
// sequencing shifter directions, output enables and PARD#/PAWR# with programmable phase lengths.
module bbus_master #(
    parameter int unsigned TURN_CYCLES   = 1,
    parameter int unsigned SETUP_CYCLES  = 1,
    parameter int unsigned STROBE_CYCLES = 2,
    parameter int unsigned HOLD_CYCLES   = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [7:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rdata_o,
    output logic       busy_o,
    output logic       pard_n_o,
    output logic       pawr_n_o,
    output logic       lvl_pa_dir_o,
    output logic       lvl_pd_dir_o,
    output logic [7:0] pa_out_o,
    output logic       pa_oe_o,
    output logic [7:0] pd_out_o,
    output logic       pd_oe_o,
    input  logic [7:0] pd_in_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TURN,
        S_SETUP,
        S_STROBE,
        S_HOLD,
        S_RELEASE
    } state_t;

    localparam logic [3:0] TURN_LD   = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYCLES - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYCLES - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       op_write_q, op_write_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic [7:0] rdata_q, rdata_d;
    logic       pard_n_q, pard_n_d;
    logic       pawr_n_q, pawr_n_d;
    logic       lvl_pa_q, lvl_pa_d;
    logic       lvl_pd_q, lvl_pd_d;
    logic [7:0] pa_out_q, pa_out_d;
    logic       pa_oe_q, pa_oe_d;
    logic [7:0] pd_out_q, pd_out_d;
    logic       pd_oe_q, pd_oe_d;

    logic       last;
    logic       accept;
    logic [3:0] cnt_dec;

    assign last    = (cnt_q == 4'd0);
    assign cnt_dec = cnt_q - 4'd1;
    // Ready is only ever high in IDLE or the final RELEASE cycle, so a command can
    // overlap the completion edge and keep the back-to-back period equal to latency.
    assign accept  = cmd_valid_i && ready_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            op_write_q  <= 1'b0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rdata_q     <= 8'h00;
            pard_n_q    <= 1'b1;
            pawr_n_q    <= 1'b1;
            lvl_pa_q    <= 1'b0;
            lvl_pd_q    <= 1'b0;
            pa_out_q    <= 8'h00;
            pa_oe_q     <= 1'b0;
            pd_out_q    <= 8'h00;
            pd_oe_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            pard_n_q    <= pard_n_d;
            pawr_n_q    <= pawr_n_d;
            lvl_pa_q    <= lvl_pa_d;
            lvl_pd_q    <= lvl_pd_d;
            pa_out_q    <= pa_out_d;
            pa_oe_q     <= pa_oe_d;
            pd_out_q    <= pd_out_d;
            pd_oe_q     <= pd_oe_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        ready_d     = 1'b0;
        rsp_valid_d = 1'b0;
        rdata_d     = rdata_q;
        pard_n_d    = 1'b1;
        pawr_n_d    = 1'b1;
        lvl_pa_d    = lvl_pa_q;
        lvl_pd_d    = lvl_pd_q;
        pa_out_d    = pa_out_q;
        pa_oe_d     = pa_oe_q;
        pd_out_d    = pd_out_q;
        pd_oe_d     = pd_oe_q;

        case (state_q)
            S_IDLE: begin
                ready_d = 1'b1;
            end
            S_TURN: begin
                if (last) begin
                    state_d = S_SETUP;
                    cnt_d   = SETUP_LD;
                    pa_oe_d = 1'b1;
                    pd_oe_d = op_write_q;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_SETUP: begin
                if (last) begin
                    state_d  = S_STROBE;
                    cnt_d    = STROBE_LD;
                    pawr_n_d = ~op_write_q;
                    pard_n_d = op_write_q;
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_STROBE: begin
                if (last) begin
                    state_d = S_HOLD;
                    cnt_d   = HOLD_LD;
                    if (!op_write_q) begin
                        rdata_d = pd_in_i;
                    end
                end else begin
                    cnt_d    = cnt_dec;
                    pawr_n_d = ~op_write_q;
                    pard_n_d = op_write_q;
                end
            end
            S_HOLD: begin
                if (last) begin
                    state_d = S_RELEASE;
                    cnt_d   = TURN_LD;
                    pa_oe_d = 1'b0;
                    pd_oe_d = 1'b0;
                    ready_d = (TURN_LD == 4'd0);
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            S_RELEASE: begin
                if (last) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    lvl_pa_d    = 1'b0;
                    lvl_pd_d    = 1'b0;
                    ready_d     = 1'b1;
                end else begin
                    cnt_d   = cnt_dec;
                    ready_d = (cnt_q == 4'd1);
                end
            end
            default: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end
        endcase

        if (accept) begin
            state_d    = S_TURN;
            cnt_d      = TURN_LD;
            op_write_d = cmd_write_i;
            pa_out_d   = cmd_addr_i;
            pd_out_d   = cmd_wdata_i;
            lvl_pa_d   = 1'b1;
            lvl_pd_d   = cmd_write_i;
            ready_d    = 1'b0;
        end
    end

    assign cmd_ready_o  = ready_q;
    assign busy_o       = ~ready_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_rdata_o  = rdata_q;
    assign pard_n_o     = pard_n_q;
    assign pawr_n_o     = pawr_n_q;
    assign lvl_pa_dir_o = lvl_pa_q;
    assign lvl_pd_dir_o = lvl_pd_q;
    assign pa_out_o     = pa_out_q;
    assign pa_oe_o      = pa_oe_q;
    assign pd_out_o     = pd_out_q;
    assign pd_oe_o      = pd_oe_q;

endmodule

// File: tb/tb_bbus_master.sv
// Directed bench for bbus_master: default-timing instance plus a slow-timing instance.
module tb_bbus_master;

    logic       clk_i = 1'b0;
    logic       rst_n_i;
    logic       cmd_valid_i, cmd_valid2_i;
    logic       cmd_write_i;
    logic [7:0] cmd_addr_i, cmd_wdata_i, pd_in_i;

    logic       cmd_ready_o, rsp_valid_o, busy_o, pard_n_o, pawr_n_o;
    logic       lvl_pa_dir_o, lvl_pd_dir_o, pa_oe_o, pd_oe_o;
    logic [7:0] rsp_rdata_o, pa_out_o, pd_out_o;

    logic       cmd_ready2_o, rsp_valid2_o, busy2_o, pard_n2_o, pawr_n2_o;
    logic       lvl_pa_dir2_o, lvl_pd_dir2_o, pa_oe2_o, pd_oe2_o;
    logic [7:0] rsp_rdata2_o, pa_out2_o, pd_out2_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    bbus_master u_dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .busy_o(busy_o),
        .pard_n_o(pard_n_o), .pawr_n_o(pawr_n_o),
        .lvl_pa_dir_o(lvl_pa_dir_o), .lvl_pd_dir_o(lvl_pd_dir_o),
        .pa_out_o(pa_out_o), .pa_oe_o(pa_oe_o),
        .pd_out_o(pd_out_o), .pd_oe_o(pd_oe_o), .pd_in_i(pd_in_i)
    );

    bbus_master #(.TURN_CYCLES(2), .SETUP_CYCLES(2), .STROBE_CYCLES(4), .HOLD_CYCLES(2)) u_dut_slow (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cmd_valid_i(cmd_valid2_i), .cmd_ready_o(cmd_ready2_o),
        .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
        .rsp_valid_o(rsp_valid2_o), .rsp_rdata_o(rsp_rdata2_o), .busy_o(busy2_o),
        .pard_n_o(pard_n2_o), .pawr_n_o(pawr_n2_o),
        .lvl_pa_dir_o(lvl_pa_dir2_o), .lvl_pd_dir_o(lvl_pd_dir2_o),
        .pa_out_o(pa_out2_o), .pa_oe_o(pa_oe2_o),
        .pd_out_o(pd_out2_o), .pd_oe_o(pd_oe2_o), .pd_in_i(pd_in_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected default-timing outputs k cycles after the acceptance edge.
    task automatic check_default(input int k, input bit wr, input bit prev_rsp,
                                 input logic [7:0] a, input logic [7:0] d);
        bit in_oe, in_stb;
        in_oe  = (k >= 1) && (k < 5);
        in_stb = (k >= 2) && (k < 4);
        chk($sformatf("k%0d lvl_pa_dir", k), 32'(lvl_pa_dir_o), 32'(k < 6));
        chk($sformatf("k%0d lvl_pd_dir", k), 32'(lvl_pd_dir_o), 32'(wr && (k < 6)));
        chk($sformatf("k%0d pa_oe", k),      32'(pa_oe_o),      32'(in_oe));
        chk($sformatf("k%0d pd_oe", k),      32'(pd_oe_o),      32'(wr && in_oe));
        chk($sformatf("k%0d pawr_n", k),     32'(pawr_n_o),     32'(!(wr && in_stb)));
        chk($sformatf("k%0d pard_n", k),     32'(pard_n_o),     32'(!(!wr && in_stb)));
        chk($sformatf("k%0d rsp_valid", k),  32'(rsp_valid_o),  32'((k == 6) || (k == 0 && prev_rsp)));
        chk($sformatf("k%0d cmd_ready", k),  32'(cmd_ready_o),  32'(k >= 5));
        chk($sformatf("k%0d busy", k),       32'(busy_o),       32'(k < 5));
        chk($sformatf("k%0d pa_out", k),     32'(pa_out_o),     32'(a));
        chk($sformatf("k%0d pd_out", k),     32'(pd_out_o),     32'(d));
    endtask

    // Called at a negedge; returns right after the acceptance edge E0.
    task automatic issue(input bit wr, input logic [7:0] a, input logic [7:0] d);
        cmd_valid_i = 1'b1;
        cmd_write_i = wr;
        cmd_addr_i  = a;
        cmd_wdata_i = d;
        @(posedge clk_i);
    endtask

    task automatic run_default(input bit wr, input logic [7:0] a, input logic [7:0] d,
                               input logic [7:0] rd_bus);
        issue(wr, a, d);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            check_default(k, wr, 1'b0, a, d);
            if (k == 6 && !wr) chk("rdata_at_e6", 32'(rsp_rdata_o), 32'(rd_bus));
            if (k == 0) cmd_valid_i = 1'b0;
            if (k == 2) cmd_valid_i = 1'b1;
            if (k == 3) cmd_valid_i = 1'b0;
            pd_in_i = (k >= 1 && k <= 3) ? rd_bus : 8'hFF;
        end
    endtask

    initial begin
        rst_n_i      = 1'b0;
        cmd_valid_i  = 1'b0;
        cmd_valid2_i = 1'b0;
        cmd_write_i  = 1'b0;
        cmd_addr_i   = 8'h00;
        cmd_wdata_i  = 8'h00;
        pd_in_i      = 8'hFF;

        // Reset held while inputs toggle
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            cmd_valid_i = ~cmd_valid_i;
            cmd_write_i = ~cmd_write_i;
            cmd_addr_i  = cmd_addr_i + 8'h11;
            cmd_wdata_i = cmd_wdata_i + 8'h22;
        end
        @(negedge clk_i);
        chk("rst cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst rsp_rdata", 32'(rsp_rdata_o), 32'h00);
        chk("rst pard_n", 32'(pard_n_o), 32'd1);
        chk("rst pawr_n", 32'(pawr_n_o), 32'd1);
        chk("rst lvl_pa_dir", 32'(lvl_pa_dir_o), 32'd0);
        chk("rst lvl_pd_dir", 32'(lvl_pd_dir_o), 32'd0);
        chk("rst pa_oe", 32'(pa_oe_o), 32'd0);
        chk("rst pd_oe", 32'(pd_oe_o), 32'd0);
        chk("rst pa_out", 32'(pa_out_o), 32'h00);
        chk("rst pd_out", 32'(pd_out_o), 32'h00);
        cmd_valid_i = 1'b0;
        rst_n_i     = 1'b1;
        @(negedge clk_i);

        // Write 0x18 <- 0xA5, then read 0x39 returning 0x5C
        run_default(1'b1, 8'h18, 8'hA5, 8'hFF);
        chk("write keeps rdata", 32'(rsp_rdata_o), 32'h00);
        run_default(1'b0, 8'h39, 8'h00, 8'h5C);
        chk("read rdata", 32'(rsp_rdata_o), 32'h5C);

        // Back-to-back: write then read with cmd_valid held, plus a stray pulse
        issue(1'b1, 8'h2C, 8'h4B);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk_i);
            if (k < 6) check_default(k, 1'b1, 1'b0, 8'h2C, 8'h4B);
            else       check_default(k - 6, 1'b0, 1'b1, 8'h3F, 8'h11);
            if (k == 6)  chk("b2b rdata kept", 32'(rsp_rdata_o), 32'h5C);
            if (k == 12) chk("b2b rdata new", 32'(rsp_rdata_o), 32'h77);
            if (k == 0) begin
                cmd_write_i = 1'b0;
                cmd_addr_i  = 8'h3F;
                cmd_wdata_i = 8'h11;
            end
            if (k == 6) cmd_valid_i = 1'b0;
            if (k == 8) cmd_valid_i = 1'b1;
            if (k == 9) cmd_valid_i = 1'b0;
            pd_in_i = (k >= 7 && k <= 9) ? 8'h77 : 8'hFF;
        end

        // Asynchronous reset during the strobe phase of a write
        issue(1'b1, 8'h55, 8'hAA);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        chk("pre-rst pawr_n", 32'(pawr_n_o), 32'd0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("async pawr_n", 32'(pawr_n_o), 32'd1);
        chk("async pa_oe", 32'(pa_oe_o), 32'd0);
        chk("async pd_oe", 32'(pd_oe_o), 32'd0);
        chk("async lvl_pd_dir", 32'(lvl_pd_dir_o), 32'd0);
        chk("async cmd_ready", 32'(cmd_ready_o), 32'd1);
        chk("async rsp_rdata", 32'(rsp_rdata_o), 32'h00);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk_i);
            chk($sformatf("post-rst rsp_valid %0d", k), 32'(rsp_valid_o), 32'd0);
        end
        run_default(1'b0, 8'h21, 8'h00, 8'h3C);
        chk("post-rst read rdata", 32'(rsp_rdata_o), 32'h3C);

        // Slow instance: TURN=2 SETUP=2 STROBE=4 HOLD=2
        cmd_valid2_i = 1'b1;
        cmd_write_i  = 1'b1;
        cmd_addr_i   = 8'h18;
        cmd_wdata_i  = 8'hA5;
        @(posedge clk_i);
        for (int k = 0; k < 14; k++) begin
            @(negedge clk_i);
            if (k == 0) cmd_valid2_i = 1'b0;
            chk($sformatf("slow k%0d pawr_n", k), 32'(pawr_n2_o), 32'(!(k >= 4 && k < 8)));
            chk($sformatf("slow k%0d pard_n", k), 32'(pard_n2_o), 32'd1);
            chk($sformatf("slow k%0d pa_oe", k), 32'(pa_oe2_o), 32'(k >= 2 && k < 10));
            chk($sformatf("slow k%0d pd_oe", k), 32'(pd_oe2_o), 32'(k >= 2 && k < 10));
            chk($sformatf("slow k%0d lvl_pd_dir", k), 32'(lvl_pd_dir2_o), 32'(k < 12));
            chk($sformatf("slow k%0d rsp_valid", k), 32'(rsp_valid2_o), 32'(k == 12));
            chk($sformatf("slow k%0d pa_out", k), 32'(pa_out2_o), 32'h18);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
